// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a word-addressed memory. Independent write and read FSMs
// each handle one INCR burst at a time. Memory contents survive reset.
module axi_mem_responder #(
  parameter int AddrWidth         = 64,
  parameter int DataWidth         = 512,
  parameter int DataWidthBytesLog = 6,
  parameter int MemDepthLog       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axi_AWVALID,
  output logic                   s_axi_AWREADY,
  input  logic [AddrWidth-1:0]   s_axi_AWADDR,
  input  logic                   s_axi_AWID,
  input  logic [7:0]             s_axi_AWLEN,
  input  logic [2:0]             s_axi_AWSIZE,
  input  logic [1:0]             s_axi_AWBURST,
  input  logic                   s_axi_WVALID,
  output logic                   s_axi_WREADY,
  input  logic [DataWidth-1:0]   s_axi_WDATA,
  input  logic [DataWidth/8-1:0] s_axi_WSTRB,
  input  logic                   s_axi_WLAST,
  output logic                   s_axi_BVALID,
  input  logic                   s_axi_BREADY,
  output logic [1:0]             s_axi_BRESP,
  output logic                   s_axi_BID,
  input  logic                   s_axi_ARVALID,
  output logic                   s_axi_ARREADY,
  input  logic [AddrWidth-1:0]   s_axi_ARADDR,
  input  logic                   s_axi_ARID,
  input  logic [7:0]             s_axi_ARLEN,
  input  logic [2:0]             s_axi_ARSIZE,
  input  logic [1:0]             s_axi_ARBURST,
  output logic                   s_axi_RVALID,
  input  logic                   s_axi_RREADY,
  output logic [DataWidth-1:0]   s_axi_RDATA,
  output logic                   s_axi_RLAST,
  output logic                   s_axi_RID,
  output logic [1:0]             s_axi_RRESP
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int Depth     = 1 << MemDepthLog;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DataWidth-1:0] mem [Depth];

  // Holds the address channels off while reset is high and until the first edge after release.
  logic ready_en;

  w_state_t               w_state, w_state_next;
  logic [MemDepthLog-1:0] w_idx;
  logic [7:0]             w_len, w_cnt;
  logic                   w_id, w_err;
  logic                   aw_fire, w_fire, w_final;

  r_state_t               r_state, r_state_next;
  logic [MemDepthLog-1:0] r_idx;
  logic [7:0]             r_len, r_cnt;
  logic                   r_id;
  logic                   ar_fire, r_fire, r_final;

  logic unused_ok;
  assign unused_ok = ^{s_axi_AWSIZE, s_axi_AWBURST, s_axi_ARSIZE, s_axi_ARBURST,
                       s_axi_AWADDR, s_axi_ARADDR};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  assign aw_fire = s_axi_AWVALID && s_axi_AWREADY;
  assign w_fire  = s_axi_WVALID && (w_state == W_DATA);
  assign w_final = (w_cnt == w_len);

  always_comb begin
    w_state_next  = w_state;
    s_axi_AWREADY = 1'b0;
    s_axi_WREADY  = 1'b0;
    s_axi_BVALID  = 1'b0;
    s_axi_BRESP   = 2'b00;
    s_axi_BID     = w_id;
    unique case (w_state)
      W_IDLE: begin
        s_axi_AWREADY = ready_en;
        if (aw_fire) w_state_next = W_DATA;
      end
      W_DATA: begin
        s_axi_WREADY = 1'b1;
        if (w_fire && w_final) w_state_next = W_RESP;
      end
      W_RESP: begin
        s_axi_BVALID = 1'b1;
        s_axi_BRESP  = w_err ? 2'b10 : 2'b00;
        if (s_axi_BREADY) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // A WLAST that disagrees with the beat count flags SLVERR but does not cut the burst short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_id    <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_next;
      if (aw_fire) begin
        w_idx <= s_axi_AWADDR[DataWidthBytesLog+MemDepthLog-1:DataWidthBytesLog];
        w_len <= s_axi_AWLEN;
        w_id  <= s_axi_AWID;
        w_cnt <= '0;
        w_err <= 1'b0;
      end
      if (w_fire) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 1'b1;
        if (s_axi_WLAST != w_final) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (s_axi_WSTRB[b]) mem[w_idx][b*8 +: 8] <= s_axi_WDATA[b*8 +: 8];
      end
    end
  end

  assign ar_fire = s_axi_ARVALID && s_axi_ARREADY;
  assign r_fire  = s_axi_RREADY && (r_state == R_DATA);
  assign r_final = (r_cnt == r_len);

  // Asynchronous read port, so a same-cycle write to this word shows up only on the next cycle.
  assign s_axi_RDATA = mem[r_idx];

  always_comb begin
    r_state_next  = r_state;
    s_axi_ARREADY = 1'b0;
    s_axi_RVALID  = 1'b0;
    s_axi_RLAST   = 1'b0;
    s_axi_RID     = r_id;
    s_axi_RRESP   = 2'b00;
    unique case (r_state)
      R_IDLE: begin
        s_axi_ARREADY = ready_en;
        if (ar_fire) r_state_next = R_DATA;
      end
      R_DATA: begin
        s_axi_RVALID = 1'b1;
        s_axi_RLAST  = r_final;
        if (r_fire && r_final) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_id    <= 1'b0;
    end else begin
      r_state <= r_state_next;
      if (ar_fire) begin
        r_idx <= s_axi_ARADDR[DataWidthBytesLog+MemDepthLog-1:DataWidthBytesLog];
        r_len <= s_axi_ARLEN;
        r_id  <= s_axi_ARID;
        r_cnt <= '0;
      end
      if (r_fire) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: table of write/read-back bursts checked
// against a byte-lane memory model, plus hand sequences for stalls, collisions and reset.
module tb_axi_mem_responder;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DBL   = 3;
  localparam int MDL   = 4;
  localparam int DEPTH = 16;
  localparam int SW    = DW / 8;
  localparam int LIMIT = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          AWVALID, AWREADY, AWID, WVALID, WREADY, WLAST;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic [1:0]    AWBURST, ARBURST, BRESP, RRESP;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic          BVALID, BREADY, BID, ARVALID, ARREADY, ARID;
  logic          RVALID, RREADY, RLAST, RID;

  axi_mem_responder #(
    .AddrWidth(AW), .DataWidth(DW), .DataWidthBytesLog(DBL), .MemDepthLog(MDL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_AWVALID(AWVALID), .s_axi_AWREADY(AWREADY), .s_axi_AWADDR(AWADDR),
    .s_axi_AWID(AWID), .s_axi_AWLEN(AWLEN), .s_axi_AWSIZE(AWSIZE), .s_axi_AWBURST(AWBURST),
    .s_axi_WVALID(WVALID), .s_axi_WREADY(WREADY), .s_axi_WDATA(WDATA),
    .s_axi_WSTRB(WSTRB), .s_axi_WLAST(WLAST),
    .s_axi_BVALID(BVALID), .s_axi_BREADY(BREADY), .s_axi_BRESP(BRESP), .s_axi_BID(BID),
    .s_axi_ARVALID(ARVALID), .s_axi_ARREADY(ARREADY), .s_axi_ARADDR(ARADDR),
    .s_axi_ARID(ARID), .s_axi_ARLEN(ARLEN), .s_axi_ARSIZE(ARSIZE), .s_axi_ARBURST(ARBURST),
    .s_axi_RVALID(RVALID), .s_axi_RREADY(RREADY), .s_axi_RDATA(RDATA),
    .s_axi_RLAST(RLAST), .s_axi_RID(RID), .s_axi_RRESP(RRESP)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic          id;
    int            wlast_mode;
    logic [SW-1:0] strb;
    logic [DW-1:0] base;
    logic [1:0]    exp_bresp;
  } burst_vec_t;

  burst_vec_t    vecs [7];
  logic [DW-1:0] model_mem [DEPTH];
  int            vectors_applied = 0;
  int            miscompares = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  function automatic int idxOf(input logic [AW-1:0] a);
    return int'(a[DBL+MDL-1:DBL]);
  endfunction

  // wlast_mode: 0 = on final beat, 1 = on beat 0 only, 2 = never.
  task automatic doWrite(input logic [AW-1:0] addr, input logic [7:0] len, input logic id,
                         input int wlast_mode, input logic [SW-1:0] strb,
                         input logic [DW-1:0] base, input logic [1:0] exp_bresp);
    int n;
    int idx;
    @(negedge clk);
    AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWID = id; AWSIZE = 3'd3; AWBURST = 2'b01;
    n = 0;
    while (!AWREADY && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) begin checkOutput("aw_timeout", 1, 0); AWVALID = 1'b0; return; end
    @(negedge clk);
    AWVALID = 1'b0;
    idx = idxOf(addr);
    for (int b = 0; b <= int'(len); b++) begin
      WVALID = 1'b1;
      WDATA  = base + DW'(b);
      WSTRB  = strb;
      WLAST  = (wlast_mode == 0) ? (b == int'(len)) : (wlast_mode == 1) ? (b == 0) : 1'b0;
      n = 0;
      while (!WREADY && n < LIMIT) begin @(negedge clk); n++; end
      if (n >= LIMIT) begin checkOutput("w_timeout", 1, 0); WVALID = 1'b0; return; end
      for (int k = 0; k < SW; k++) if (strb[k]) model_mem[idx][k*8 +: 8] = WDATA[k*8 +: 8];
      idx = (idx + 1) % DEPTH;
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    n = 0;
    while (!BVALID && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) begin checkOutput("b_timeout", 1, 0); return; end
    checkOutput("bresp", BRESP, exp_bresp);
    checkOutput("bid", BID, id);
    BREADY = 1'b0;
    @(negedge clk);
    checkOutput("bvalid_held", BVALID, 1);
    checkOutput("bresp_held", BRESP, exp_bresp);
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    checkOutput("bvalid_drop", BVALID, 0);
  endtask

  // stall inserts one RREADY=0 cycle before accepting beat 1.
  task automatic doRead(input logic [AW-1:0] addr, input logic [7:0] len, input logic id,
                        input bit stall);
    int n;
    int idx;
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARID = id; ARSIZE = 3'd3; ARBURST = 2'b01;
    n = 0;
    while (!ARREADY && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) begin checkOutput("ar_timeout", 1, 0); ARVALID = 1'b0; return; end
    @(negedge clk);
    ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      idx = (idxOf(addr) + b) % DEPTH;
      if (stall && b == 1) begin
        RREADY = 1'b0;
        @(negedge clk);
        checkOutput("rdata_stall", RDATA, model_mem[idx]);
        checkOutput("rlast_stall", RLAST, (b == int'(len)));
      end
      RREADY = 1'b1;
      checkOutput("rvalid", RVALID, 1);
      checkOutput("rdata", RDATA, model_mem[idx]);
      checkOutput("rlast", RLAST, (b == int'(len)));
      checkOutput("rid", RID, id);
      checkOutput("rresp", RRESP, 0);
      @(negedge clk);
    end
    RREADY = 1'b0;
    checkOutput("rvalid_end", RVALID, 0);
  endtask

  task automatic applyStimulus(input burst_vec_t v);
    doWrite(v.addr, v.len, v.id, v.wlast_mode, v.strb, v.base, v.exp_bresp);
    doRead(v.addr, v.len, ~v.id, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 8'd255, 1'b0, 0, 8'hFF, 64'hA5A5_0000_0000_0000, 2'b00};
    vecs[1] = '{32'h0000_0040, 8'd3,   1'b1, 0, 8'hFF, 64'hD0D0_0000_0000_0000, 2'b00};
    vecs[2] = '{32'h0000_0010, 8'd1,   1'b0, 1, 8'hFF, 64'h2222_0000_0000_0000, 2'b10};
    vecs[3] = '{32'h0000_0020, 8'd1,   1'b1, 2, 8'hFF, 64'h3333_0000_0000_0000, 2'b10};
    vecs[4] = '{32'h0000_0070, 8'd3,   1'b0, 0, 8'hFF, 64'h7777_0000_0000_0000, 2'b00};
    vecs[5] = '{32'hFFFF_FF18, 8'd0,   1'b1, 0, 8'hFF, 64'h5151_0000_0000_0000, 2'b00};
    vecs[6] = '{32'h0000_0060, 8'd1,   1'b0, 0, 8'hF0, 64'h0000_0000_0000_0000, 2'b00};
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    rst = 1'b1;
    AWVALID = 0; AWADDR = '0; AWID = 0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    WVALID = 0; WDATA = '0; WSTRB = '0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARADDR = '0; ARID = 0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; RREADY = 0;
    #1;
    checkOutput("rst_awready", AWREADY, 0);
    checkOutput("rst_arready", ARREADY, 0);
    checkOutput("rst_bvalid", BVALID, 0);
    checkOutput("rst_rvalid", RVALID, 0);
    checkOutput("rst_wready", WREADY, 0);
    checkOutput("rst_rlast", RLAST, 0);
    checkOutput("rst_ids_resps", {BID, RID, BRESP, RRESP}, 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_awready_edges", AWREADY, 0);
    rst = 1'b0;
    #1;
    checkOutput("release_awready_pre_edge", AWREADY, 0);
    @(posedge clk); #1;
    checkOutput("release_awready", AWREADY, 1);
    checkOutput("release_arready", ARREADY, 1);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Strobe merge: low four lanes cleared over an all-ones word.
    doWrite(32'h28, 8'd0, 1'b0, 0, 8'hFF, {DW{1'b1}}, 2'b00);
    doWrite(32'h28, 8'd0, 1'b0, 0, 8'h0F, 64'h0, 2'b00);
    doRead(32'h28, 8'd0, 1'b1, 1'b0);

    // Wrap from depth-2 with a single-cycle RREADY stall.
    doRead(32'h70, 8'd3, 1'b1, 1'b1);

    // Same-word write and read in one cycle.
    doWrite(32'h30, 8'd0, 1'b0, 0, 8'hFF, 64'h1111_2222_3333_4444, 2'b00);
    @(negedge clk);
    AWVALID = 1; AWADDR = 32'h30; AWLEN = 0; AWID = 1;
    ARVALID = 1; ARADDR = 32'h30; ARLEN = 0; ARID = 1;
    checkOutput("conc_awready", AWREADY, 1);
    checkOutput("conc_arready", ARREADY, 1);
    @(negedge clk);
    AWVALID = 0; ARVALID = 0;
    WVALID = 1; WDATA = 64'h5555_6666_7777_8888; WSTRB = 8'hFF; WLAST = 1; RREADY = 1;
    checkOutput("conc_wready", WREADY, 1);
    checkOutput("conc_rvalid", RVALID, 1);
    checkOutput("conc_rdata_old", RDATA, 64'h1111_2222_3333_4444);
    @(negedge clk);
    WVALID = 0; WLAST = 0; RREADY = 0;
    model_mem[6] = 64'h5555_6666_7777_8888;
    checkOutput("conc_rvalid_done", RVALID, 0);
    checkOutput("conc_bvalid", BVALID, 1);
    checkOutput("conc_bresp", BRESP, 0);
    BREADY = 1;
    @(negedge clk);
    BREADY = 0;
    doRead(32'h30, 8'd0, 1'b0, 1'b0);

    // Reset in the middle of a 4-beat write and an 8-beat read.
    @(negedge clk);
    AWVALID = 1; AWADDR = 32'h50; AWLEN = 8'd3; AWID = 0;
    ARVALID = 1; ARADDR = 32'h0; ARLEN = 8'd7; ARID = 1;
    @(negedge clk);
    AWVALID = 0; ARVALID = 0;
    for (int b = 0; b < 2; b++) begin
      WVALID = 1; WDATA = 64'hBEEF_0000_0000_0000 + DW'(b); WSTRB = 8'hFF; WLAST = 0; RREADY = 1;
      checkOutput("mid_rdata", RDATA, model_mem[b]);
      model_mem[10 + b] = WDATA;
      @(negedge clk);
    end
    WVALID = 0;
    checkOutput("mid_rvalid_before_rst", RVALID, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_rvalid", RVALID, 0);
    checkOutput("mid_rst_rlast", RLAST, 0);
    checkOutput("mid_rst_wready", WREADY, 0);
    checkOutput("mid_rst_bvalid", BVALID, 0);
    checkOutput("mid_rst_arready", ARREADY, 0);
    @(negedge clk);
    RREADY = 0;
    rst = 1'b0;
    #1;
    checkOutput("mid_release_arready_pre_edge", ARREADY, 0);
    @(posedge clk); #1;
    checkOutput("mid_release_arready", ARREADY, 1);
    checkOutput("mid_release_awready", AWREADY, 1);
    checkOutput("mid_release_rvalid", RVALID, 0);
    checkOutput("mid_release_bvalid", BVALID, 0);
    doRead(32'h50, 8'd3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
